memory_module: RTL and testbench
================================

// Module: memory_module
// PURPOSE
//  Byte-wide memory subsystem: 256x8 main RAM behind a 16-line direct-mapped write-back cache (1 byte/line).
//  A processor issues one request at a time (start/cntrl/addr/dataIn) and waits for the dataReady pulse.
//  Supports direct and indirect (pointer-through-memory) addressing.
//  Exposes FSM state, hit/clean flags and the cache write address for debug.
// PARAMETERS
//  none (fixed: 8-bit address, 8-bit data, 16 lines, tag=addr[7:4], index=addr[3:0])
// PORTS
//  clk            in   1   single clock; all logic on posedge
//  clrRAM         in   1   synchronous, active-high reset; also clears RAM and cache
//  start          in   1   request strobe, sampled in IDLE
//  isIndirect     in   1   1: effective address = mem[addr]
//  cntrl          in   2   op: 11 write-back write, 10 write-through write, 01 read, 00 read+flush
//  addr           in   8   request address
//  dataIn         in   8   write data
//  dataOut        out  8   read data (writes: echo of written byte)
//  dataReady      out  1   1-cycle completion pulse
//  TEMPstateTEMP  out  19  one-hot FSM state
//  hitCleanTEMP   out  2   {hit, clean} from last LOOKUP
//  wCacheAddr     out  8   {tag,index} of last cache line written
// BEHAVIOUR
//  Reset (clrRAM=1 at posedge, priority over everything, aborts any op): state=IDLE; RAM all 0x00;
//   all lines invalid/clean/tag 0; dataOut=0, dataReady=0, hitCleanTEMP=00, wCacheAddr=0.
//  One-hot states, bit index: 18 IDLE, 0 LOOKUP, 1 WB_ADDR, 2 WB_WAIT, 3 WB_DONE, 4 FILL_ADDR,
//   5 FILL_WAIT, 6 FILL_DONE, 7 ACCESS, 8 IND_PTR, 9 RD_OUT, 10 WR_CACHE, 11 WT_ADDR, 12 WT_WAIT,
//   13 WT_DONE, 14 FL_ADDR, 15 FL_WAIT, 16 FL_DONE, 17 READY. Exactly one bit set at all times.
//  IDLE: if start=1 latch addr, cntrl, isIndirect, dataIn; eff<=addr; phase<=isIndirect?PTR:FINAL -> LOOKUP.
//   start=0 stays in IDLE. Inputs changing after acceptance have no effect.
//  LOOKUP: hit=valid&&tag==eff[7:4]; clean=!dirty of line eff[3:0]; latch hitCleanTEMP.
//   hit -> ACCESS; miss&clean -> FILL_ADDR; miss&dirty -> WB_ADDR.
//  WB_*: write victim byte to RAM[{victim tag,index}] (committed in WB_DONE), clear dirty -> FILL_ADDR.
//  FILL_*: read RAM[eff]; FILL_DONE writes line (valid=1, clean, tag), wCacheAddr<=eff -> ACCESS.
//  ACCESS: phase PTR -> IND_PTR; FINAL read (01/00) -> RD_OUT; FINAL write (1x) -> WR_CACHE.
//  IND_PTR: eff<=cache byte, phase<=FINAL -> LOOKUP (second lookup may itself miss/write back).
//  RD_OUT: dataOut<=cache byte; cntrl=01 -> READY; cntrl=00 -> FL_ADDR if line dirty else
//   invalidate line -> READY.
//  WR_CACHE: line<=dataIn, wCacheAddr<=eff, dataOut<=dataIn; cntrl=11: dirty=1 -> READY;
//   cntrl=10: dirty=0 -> WT_ADDR.
//  WT_*: RAM[eff]<=dataIn at WT_DONE -> READY.  FL_*: RAM[eff]<=line at FL_DONE, invalidate -> READY.
//  READY: dataReady=1 this cycle only -> IDLE. dataReady=0 in every other state.
//  Latency (start sampled in IDLE at cycle 0, dataReady high in cycle n): direct read hit n=4;
//   clean miss +3; dirty miss +6; indirect adds LOOKUP+ACCESS+IND_PTR (+miss costs) for the pointer.
//  RAM access = 3 states (addr, wait, done); no other RAM port. Address arithmetic 8-bit, no wrap issues.
//  Reads never modify RAM; cache+RAM together always hold the latest value for every address.
// TESTING
//  Reset: clrRAM=1 one cycle -> state=IDLE (bit18), dataReady=0, read 0x35 (cntrl=01) returns 0x00.
//  Write-back: write 0x35<=0xCA (11), read 0x35 -> hitCleanTEMP=10, dataOut=0xCA, dataReady 4 cycles after.
//  Eviction: after above, read 0x45 -> miss dirty (hitClean=00), RAM[0x35]=0xCA, wCacheAddr=0x45;
//   read 0x35 again -> 0xCA.
//  Indirect: write 0x10<=0xEF, 0xEF<=0x10; read 0x10 isIndirect=1 -> dataOut=0x10.
//  Write-through/flush: write 0x22<=0xDD (10) -> RAM[0x22]=0xDD, line clean; cntrl=00 on dirty line
//   -> RAM updated, line invalid, next read misses.
//  Reset mid-op: clrRAM during FILL_WAIT -> next cycle IDLE, no dataReady pulse.

Source files
------------

// File: rtl/memory_if.sv
// Request/response bundle between a processor and the byte-wide memory subsystem.
// Debug taps (state, hit/clean, last cache write address) ride along with the response.
interface memory_if;
  logic        start;
  logic        isIndirect;
  logic [1:0]  cntrl;
  logic [7:0]  addr;
  logic [7:0]  dataIn;
  logic [7:0]  dataOut;
  logic        dataReady;
  logic [18:0] TEMPstateTEMP;
  logic [1:0]  hitCleanTEMP;
  logic [7:0]  wCacheAddr;

  modport master (
    output start, isIndirect, cntrl, addr, dataIn,
    input  dataOut, dataReady, TEMPstateTEMP,
    input  hitCleanTEMP, wCacheAddr
  );

  modport slave (
    input  start, isIndirect, cntrl, addr, dataIn,
    output dataOut, dataReady, TEMPstateTEMP,
    output hitCleanTEMP, wCacheAddr
  );
endinterface

// File: rtl/memory_module.sv
// 256x8 RAM behind a 16-line direct-mapped write-back cache, one byte per line.
// Single outstanding request; optional pointer-through-memory addressing.
module memory_module (
  input logic    clk,
  input logic    clrRAM,
  memory_if.slave bus
);
  localparam int LOOKUP    = 0;
  localparam int WB_ADDR   = 1;
  localparam int WB_WAIT   = 2;
  localparam int WB_DONE   = 3;
  localparam int FILL_ADDR = 4;
  localparam int FILL_WAIT = 5;
  localparam int FILL_DONE = 6;
  localparam int ACCESS    = 7;
  localparam int IND_PTR   = 8;
  localparam int RD_OUT    = 9;
  localparam int WR_CACHE  = 10;
  localparam int WT_ADDR   = 11;
  localparam int WT_WAIT   = 12;
  localparam int WT_DONE   = 13;
  localparam int FL_ADDR   = 14;
  localparam int FL_WAIT   = 15;
  localparam int FL_DONE   = 16;
  localparam int READY     = 17;
  localparam int IDLE      = 18;

  localparam logic [18:0] S_LOOKUP    = 19'd1 << LOOKUP;
  localparam logic [18:0] S_WB_ADDR   = 19'd1 << WB_ADDR;
  localparam logic [18:0] S_WB_WAIT   = 19'd1 << WB_WAIT;
  localparam logic [18:0] S_WB_DONE   = 19'd1 << WB_DONE;
  localparam logic [18:0] S_FILL_ADDR = 19'd1 << FILL_ADDR;
  localparam logic [18:0] S_FILL_WAIT = 19'd1 << FILL_WAIT;
  localparam logic [18:0] S_FILL_DONE = 19'd1 << FILL_DONE;
  localparam logic [18:0] S_ACCESS    = 19'd1 << ACCESS;
  localparam logic [18:0] S_IND_PTR   = 19'd1 << IND_PTR;
  localparam logic [18:0] S_RD_OUT    = 19'd1 << RD_OUT;
  localparam logic [18:0] S_WR_CACHE  = 19'd1 << WR_CACHE;
  localparam logic [18:0] S_WT_ADDR   = 19'd1 << WT_ADDR;
  localparam logic [18:0] S_WT_WAIT   = 19'd1 << WT_WAIT;
  localparam logic [18:0] S_WT_DONE   = 19'd1 << WT_DONE;
  localparam logic [18:0] S_FL_ADDR   = 19'd1 << FL_ADDR;
  localparam logic [18:0] S_FL_WAIT   = 19'd1 << FL_WAIT;
  localparam logic [18:0] S_FL_DONE   = 19'd1 << FL_DONE;
  localparam logic [18:0] S_READY     = 19'd1 << READY;
  localparam logic [18:0] S_IDLE      = 19'd1 << IDLE;

  logic [18:0] state;
  logic [18:0] nextState;

  logic [7:0]  ram [256];
  logic [7:0]  lineData [16];
  logic [3:0]  lineTag [16];
  logic [15:0] lineValid;
  logic [15:0] lineDirty;

  logic [1:0]  opCntrl;
  logic [7:0]  opData;
  logic [7:0]  eff;
  logic        phasePtr;
  logic [7:0]  ramAddr;
  logic [7:0]  dataOutQ;
  logic [1:0]  hitCleanQ;
  logic [7:0]  wAddrQ;

  logic [3:0]  idx;
  logic        hit;
  logic        clean;

  assign idx   = eff[3:0];
  assign hit   = lineValid[idx] && (lineTag[idx] == eff[7:4]);
  assign clean = !lineDirty[idx];

  always_ff @(posedge clk) begin
    if (clrRAM) state <= S_IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = S_IDLE;
    unique case (1'b1)
      state[IDLE]:      nextState = bus.start ? S_LOOKUP : S_IDLE;
      state[LOOKUP]:    nextState = hit   ? S_ACCESS :
                                    clean ? S_FILL_ADDR : S_WB_ADDR;
      state[WB_ADDR]:   nextState = S_WB_WAIT;
      state[WB_WAIT]:   nextState = S_WB_DONE;
      state[WB_DONE]:   nextState = S_FILL_ADDR;
      state[FILL_ADDR]: nextState = S_FILL_WAIT;
      state[FILL_WAIT]: nextState = S_FILL_DONE;
      state[FILL_DONE]: nextState = S_ACCESS;
      state[ACCESS]:    nextState = phasePtr   ? S_IND_PTR :
                                    opCntrl[1] ? S_WR_CACHE : S_RD_OUT;
      state[IND_PTR]:   nextState = S_LOOKUP;
      state[RD_OUT]:    nextState = (opCntrl == 2'b00 && !clean)
                                    ? S_FL_ADDR : S_READY;
      state[WR_CACHE]:  nextState = opCntrl[0] ? S_READY : S_WT_ADDR;
      state[WT_ADDR]:   nextState = S_WT_WAIT;
      state[WT_WAIT]:   nextState = S_WT_DONE;
      state[WT_DONE]:   nextState = S_READY;
      state[FL_ADDR]:   nextState = S_FL_WAIT;
      state[FL_WAIT]:   nextState = S_FL_DONE;
      state[FL_DONE]:   nextState = S_READY;
      state[READY]:     nextState = S_IDLE;
      default:          nextState = S_IDLE;
    endcase
  end

  always_comb begin
    bus.dataReady     = state[READY];
    bus.TEMPstateTEMP = state;
    bus.dataOut       = dataOutQ;
    bus.hitCleanTEMP  = hitCleanQ;
    bus.wCacheAddr    = wAddrQ;
  end

  // RAM port, cache arrays and request registers, all advanced by state
  always_ff @(posedge clk) begin
    if (clrRAM) begin
      for (int i = 0; i < 256; i++) ram[i] <= '0;
      for (int i = 0; i < 16; i++) begin
        lineData[i] <= '0;
        lineTag[i]  <= '0;
      end
      lineValid <= '0;
      lineDirty <= '0;
      opCntrl   <= '0;
      opData    <= '0;
      eff       <= '0;
      phasePtr  <= 1'b0;
      ramAddr   <= '0;
      dataOutQ  <= '0;
      hitCleanQ <= '0;
      wAddrQ    <= '0;
    end else begin
      unique case (1'b1)
        state[IDLE]: begin
          if (bus.start) begin
            opCntrl  <= bus.cntrl;
            opData   <= bus.dataIn;
            eff      <= bus.addr;
            phasePtr <= bus.isIndirect;
          end
        end
        state[LOOKUP]:  hitCleanQ <= {hit, clean};
        state[WB_ADDR]: ramAddr <= {lineTag[idx], idx};
        state[WB_DONE]: begin
          ram[ramAddr]   <= lineData[idx];
          lineDirty[idx] <= 1'b0;
        end
        state[FILL_ADDR], state[WT_ADDR], state[FL_ADDR]:
          ramAddr <= eff;
        state[FILL_DONE]: begin
          lineData[idx]  <= ram[ramAddr];
          lineTag[idx]   <= eff[7:4];
          lineValid[idx] <= 1'b1;
          lineDirty[idx] <= 1'b0;
          wAddrQ         <= eff;
        end
        state[IND_PTR]: begin
          eff      <= lineData[idx];
          phasePtr <= 1'b0;
        end
        state[RD_OUT]: begin
          dataOutQ <= lineData[idx];
          if (opCntrl == 2'b00 && clean) lineValid[idx] <= 1'b0;
        end
        state[WR_CACHE]: begin
          lineData[idx]  <= opData;
          lineDirty[idx] <= opCntrl[0];
          wAddrQ         <= eff;
          dataOutQ       <= opData;
        end
        state[WT_DONE]: ram[ramAddr] <= opData;
        state[FL_DONE]: begin
          ram[ramAddr]   <= lineData[idx];
          lineValid[idx] <= 1'b0;
          lineDirty[idx] <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_memory_module.sv
// Scoreboarded bench for memory_module: a flat 256-byte model predicts every response,
// a negedge monitor pops predictions whenever dataReady pulses.
module tb_memory_module;
  logic clk = 1'b0;
  logic clrRAM;

  memory_if bus();

  memory_module dut (
    .clk    (clk),
    .clrRAM (clrRAM),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int asserts  = 0;
  int failures = 0;

  logic [7:0] model [256];
  logic [7:0] expQ [$];
  logic       prevReady = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    asserts++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor: every completion pulse must match the oldest prediction
  always @(negedge clk) begin
    if (!clrRAM) begin
      check("onehot", int'($onehot(bus.TEMPstateTEMP)), 1);
      if (bus.dataReady) begin
        check("pulseWidth", int'(prevReady), 0);
        if (expQ.size() == 0) begin
          asserts++;
          failures++;
          $display("FAIL unexpectedReady: dataOut=0x%0h with no request pending",
                   bus.dataOut);
        end else begin
          check("dataOut", int'(bus.dataOut), int'(expQ.pop_front()));
        end
      end
    end
    prevReady = bus.dataReady;
  end

  task automatic waitIdle();
    int n = 0;
    @(negedge clk);
    while (!bus.TEMPstateTEMP[18] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.TEMPstateTEMP[18]) begin
      asserts++;
      failures++;
      $display("FAIL idleTimeout: state=0x%0h", bus.TEMPstateTEMP);
    end
  endtask

  task automatic doOp(input logic [1:0] c, input logic [7:0] a,
                      input logic [7:0] d, input logic ind, output int lat);
    logic [7:0] e;
    waitIdle();
    e = ind ? model[a] : a;
    if (c[1]) begin
      model[e] = d;
      expQ.push_back(d);
    end else begin
      expQ.push_back(model[e]);
    end
    bus.start      = 1'b1;
    bus.cntrl      = c;
    bus.addr       = a;
    bus.dataIn     = d;
    bus.isIndirect = ind;
    @(posedge clk);
    #1;
    bus.start      = 1'b0;
    bus.cntrl      = 2'($urandom);
    bus.addr       = 8'($urandom);
    bus.dataIn     = 8'($urandom);
    bus.isIndirect = 1'($urandom);
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (bus.dataReady) break;
      if (lat > 40) begin
        asserts++;
        failures++;
        $display("FAIL readyTimeout: op=%0d addr=0x%0h", c, a);
        expQ.delete();
        break;
      end
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    clrRAM = 1'b1;
    @(negedge clk);
    clrRAM = 1'b0;
    foreach (model[i]) model[i] = 8'h00;
    expQ.delete();
  endtask

  initial begin
    int lat;
    int n;
    logic [7:0] a;
    logic [1:0] c;
    logic ind;
    bus.start = 1'b0;
    bus.isIndirect = 1'b0;
    bus.cntrl = 2'b00;
    bus.addr = 8'h00;
    bus.dataIn = 8'h00;
    clrRAM = 1'b1;
    foreach (model[i]) model[i] = 8'h00;

    @(negedge clk);
    check("rstState", int'(bus.TEMPstateTEMP), 32'h40000);
    check("rstReady", int'(bus.dataReady), 0);
    check("rstDataOut", int'(bus.dataOut), 0);
    check("rstHitClean", int'(bus.hitCleanTEMP), 0);
    check("rstWAddr", int'(bus.wCacheAddr), 0);
    clrRAM = 1'b0;

    doOp(2'b01, 8'h35, 8'h00, 1'b0, lat);
    check("coldMissLat", lat, 7);
    check("coldMissHc", int'(bus.hitCleanTEMP), 2'b01);

    doOp(2'b11, 8'h35, 8'hCA, 1'b0, lat);
    check("wbWriteLat", lat, 4);
    check("wbWriteAddr", int'(bus.wCacheAddr), 8'h35);

    doOp(2'b01, 8'h35, 8'h00, 1'b0, lat);
    check("hitLat", lat, 4);
    check("hitHc", int'(bus.hitCleanTEMP), 2'b10);

    doOp(2'b01, 8'h45, 8'h00, 1'b0, lat);
    check("dirtyMissLat", lat, 10);
    check("dirtyMissHc", int'(bus.hitCleanTEMP), 2'b00);
    check("evictWAddr", int'(bus.wCacheAddr), 8'h45);

    doOp(2'b01, 8'h35, 8'h00, 1'b0, lat);
    check("refillHc", int'(bus.hitCleanTEMP), 2'b01);

    doOp(2'b11, 8'h10, 8'hEF, 1'b0, lat);
    doOp(2'b11, 8'hEF, 8'h10, 1'b0, lat);
    doOp(2'b01, 8'h10, 8'h00, 1'b1, lat);
    check("indirectEffAddr", int'(bus.hitCleanTEMP), 2'b10);

    doOp(2'b10, 8'h22, 8'hDD, 1'b0, lat);
    check("wtLat", lat, 10);
    check("wtWAddr", int'(bus.wCacheAddr), 8'h22);
    doOp(2'b01, 8'h32, 8'h00, 1'b0, lat);
    check("wtLineClean", int'(bus.hitCleanTEMP), 2'b01);
    doOp(2'b01, 8'h22, 8'h00, 1'b0, lat);

    doOp(2'b11, 8'h50, 8'h77, 1'b0, lat);
    doOp(2'b00, 8'h50, 8'h00, 1'b0, lat);
    check("flushLat", lat, 7);
    check("flushHc", int'(bus.hitCleanTEMP), 2'b10);
    doOp(2'b01, 8'h50, 8'h00, 1'b0, lat);
    check("flushInvalid", int'(bus.hitCleanTEMP[1]), 0);

    // small address pool forces conflicts on four indices
    for (int i = 0; i < 400; i++) begin
      a   = 8'($urandom_range(0, 3) * 16 + $urandom_range(0, 3));
      c   = 2'($urandom_range(0, 3));
      ind = ($urandom_range(0, 3) == 0);
      doOp(c, a, 8'($urandom), ind, lat);
    end

    waitIdle();
    bus.start = 1'b1;
    bus.cntrl = 2'b01;
    bus.addr  = 8'h77;
    bus.isIndirect = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n = 0;
    while (!bus.TEMPstateTEMP[5] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("reachFillWait", int'(bus.TEMPstateTEMP[5]), 1);
    clrRAM = 1'b1;
    @(posedge clk);
    #1;
    check("abortState", int'(bus.TEMPstateTEMP), 32'h40000);
    check("abortReady", int'(bus.dataReady), 0);
    @(negedge clk);
    clrRAM = 1'b0;
    foreach (model[i]) model[i] = 8'h00;
    expQ.delete();
    repeat (10) @(negedge clk);

    doOp(2'b01, 8'h35, 8'h00, 1'b0, lat);
    check("postRstHc", int'(bus.hitCleanTEMP), 2'b01);
    doOp(2'b01, 8'h10, 8'h00, 1'b0, lat);

    repeat (3) @(negedge clk);
    check("queueDrained", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, failures);
    $finish;
  end
endmodule
